// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: data width, fetch FSM states and the decode bubble word.
package riscv_pipe_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- inserted by decode when the IF/ID queue is empty
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Signal bundle between the fetch unit, the PC update stage, instruction memory and decode.
interface ifetch_unit_if #(
    parameter int XLEN = 32
) ();

    // Handshakes: a memory read transfers when imem_req && imem_gnt in the same cycle
    // (imem_req never waits on imem_gnt); one imem_rvalid returns each transferred read
    // at least one cycle later. The queue head transfers to decode when if_valid && id_ready.
    logic [XLEN-1:0] pc_in;
    logic            redirect;
    logic            pc_stall;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
    logic            id_ready;

    modport master (
        input  pc_in, redirect, imem_gnt, imem_rvalid, imem_rdata, id_ready,
        output pc_stall, imem_req, imem_addr, if_valid, if_pc, if_instr
    );

    modport slave (
        output pc_in, redirect, imem_gnt, imem_rvalid, imem_rdata, id_ready,
        input  pc_stall, imem_req, imem_addr, if_valid, if_pc, if_instr
    );

endinterface

// File: rtl/ifetch_fifo.sv
// DEPTH-entry {pc, instr} queue with synchronous flush; head is read straight from storage.
module ifetch_fifo #(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_instr,
    input  logic            pop,
    output logic [CW-1:0]   count,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr
);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            // a flush wins over any push or pop in the same cycle
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= push_pc;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues one outstanding memory read at a time and queues results for decode.
module ifetch_unit #(
    parameter  int XLEN  = riscv_pipe_pkg::XLEN,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    ifetch_unit_if.master                bus,
    output riscv_pipe_pkg::fetch_state_t dbg_state,
    output logic [CW-1:0]                dbg_count,
    output logic [XLEN-1:0]              dbg_req_pc
);

    import riscv_pipe_pkg::*;

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] req_pc;
    logic [CW-1:0]   count;
    logic [CW:0]     credit;
    logic            issue_ok;
    logic            fire;
    logic            push;
    logic            pop;

    // A kept response arriving this cycle already owns a queue slot; pops are not credited.
    assign credit   = {1'b0, count} + (CW + 1)'(state == WAIT && bus.imem_rvalid);
    assign issue_ok = !bus.redirect && (credit < (CW + 1)'(DEPTH))
                      && (state == IDLE || bus.imem_rvalid);

    assign bus.imem_req  = issue_ok && !reset;
    assign bus.imem_addr = bus.pc_in;
    assign fire          = bus.imem_req && bus.imem_gnt;
    assign bus.pc_stall  = !fire;

    assign push        = (state == WAIT) && bus.imem_rvalid && !bus.redirect;
    assign bus.if_valid = (count != '0);
    assign pop         = bus.if_valid && bus.id_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            req_pc <= '0;
        end else begin
            state <= state_nxt;
            if (fire) begin
                req_pc <= bus.pc_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (fire) state_nxt = WAIT;
            end
            default: begin
                // fire never coincides with redirect, so redirect+rvalid lands in IDLE
                if (bus.imem_rvalid)   state_nxt = fire ? WAIT : IDLE;
                else if (bus.redirect) state_nxt = DROP;
            end
        endcase
    end

    ifetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (bus.redirect),
        .push       (push),
        .push_pc    (req_pc),
        .push_instr (bus.imem_rdata),
        .pop        (pop),
        .count      (count),
        .head_pc    (bus.if_pc),
        .head_instr (bus.if_instr)
    );

    assign dbg_state  = state;
    assign dbg_count  = count;
    assign dbg_req_pc = req_pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit against a transaction-level model of the fetch queue.
module tb_ifetch_unit;

  import riscv_pipe_pkg::*;

  localparam int XW    = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  // clock/reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ifetch_unit_if #(.XLEN(XW)) bus ();
  fetch_state_t    dbg_state;
  logic [CW-1:0]   dbg_count;
  logic [XW-1:0]   dbg_req_pc;

  ifetch_unit #(.XLEN(XW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_count  (dbg_count),
    .dbg_req_pc (dbg_req_pc)
  );

  int n_checks = 0;
  int n_bad    = 0;

  // scoreboard: entries decode should see, oldest first, as {pc, instr}
  logic [63:0] exp_q[$];
  logic        m_busy = 1'b0;
  logic        m_keep = 1'b0;
  logic [XW-1:0] m_pc = '0;

  // environment: PC register and single-slot memory
  logic [XW-1:0] pc_reg    = '0;
  logic          mem_pend  = 1'b0;
  int            mem_delay = 0;
  logic [XW-1:0] mem_addr  = '0;

  function automatic logic [XW-1:0] mem_word(input logic [XW-1:0] a);
    return (a * 32'h9E37) ^ 32'h00500093;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // one clock cycle: check registered outputs, drive inputs, check combinational outputs, step model
  task automatic run_cycle(input bit rst, input int p_ready, input int p_gnt,
                           input int p_redir, input int max_delay);
    logic [63:0] head;
    logic [1:0]  exp_st;
    logic        rsp_now, exp_req, fire, act_fire, pop, keep_now;
    @(negedge clk);
    check_val("if_valid", 64'(bus.if_valid), 64'(exp_q.size() != 0));
    check_val("count", 64'(dbg_count), 64'(exp_q.size()));
    exp_st = !m_busy ? 2'(IDLE) : (m_keep ? 2'(WAIT) : 2'(DROP));
    check_val("state", 64'(dbg_state), 64'(exp_st));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check_val("if_pc", 64'(bus.if_pc), 64'(head[63:32]));
      check_val("if_instr", 64'(bus.if_instr), 64'(head[31:0]));
    end
    if (m_busy && m_keep) check_val("req_pc", 64'(dbg_req_pc), 64'(m_pc));

    reset        = rst;
    bus.id_ready = ($urandom_range(0, 99) < p_ready);
    bus.imem_gnt = ($urandom_range(0, 99) < p_gnt);
    bus.redirect = !rst && ($urandom_range(0, 99) < p_redir);
    rsp_now      = mem_pend && (mem_delay == 0);
    bus.imem_rvalid = rsp_now;
    bus.imem_rdata  = rsp_now ? mem_word(mem_addr) : $urandom;
    bus.pc_in       = pc_reg;
    #1;

    if (rst) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_keep = 1'b0;
      m_pc   = '0;
      check_val("rst_req", 64'(bus.imem_req), 64'd0);
      check_val("rst_stall", 64'(bus.pc_stall), 64'd1);
      check_val("rst_valid", 64'(bus.if_valid), 64'd0);
      check_val("rst_pc", 64'(bus.if_pc), 64'd0);
      check_val("rst_instr", 64'(bus.if_instr), 64'd0);
      check_val("rst_count", 64'(dbg_count), 64'd0);
      fire = 1'b0;
    end else begin
      // a queue slot is taken by everything queued plus a response being kept right now
      keep_now = m_busy && m_keep && rsp_now;
      exp_req  = !bus.redirect && (!m_busy || rsp_now)
                 && ((exp_q.size() + int'(keep_now)) < DEPTH);
      fire = exp_req && bus.imem_gnt;
      check_val("imem_req", 64'(bus.imem_req), 64'(exp_req));
      check_val("pc_stall", 64'(bus.pc_stall), 64'(!fire));
      check_val("imem_addr", 64'(bus.imem_addr), 64'(pc_reg));
      pop = (exp_q.size() != 0) && bus.id_ready;
      if (bus.redirect) begin
        exp_q.delete();
        if (rsp_now) m_busy = 1'b0;
        else         m_keep = 1'b0;
      end else begin
        if (pop) head = exp_q.pop_front();
        if (rsp_now && m_busy) begin
          if (m_keep) exp_q.push_back({m_pc, bus.imem_rdata});
          m_busy = 1'b0;
        end
        if (fire) begin
          m_busy = 1'b1;
          m_keep = 1'b1;
          m_pc   = pc_reg;
        end
      end
    end

    // environment follows the DUT's actual handshake
    act_fire = bus.imem_req && bus.imem_gnt;
    if (rsp_now) mem_pend = 1'b0;
    else if (mem_pend) mem_delay--;
    if (act_fire) begin
      mem_pend  = 1'b1;
      mem_delay = $urandom_range(0, max_delay);
      mem_addr  = pc_reg;
    end
    if (bus.redirect) pc_reg = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    else if (!bus.pc_stall) pc_reg = pc_reg + 32'd4;
  endtask

  initial begin
    bus.pc_in       = '0;
    bus.redirect    = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.id_ready    = 1'b0;

    repeat (2) run_cycle(1'b1, 0, 0, 0, 0);
    // streaming with 1-cycle memory and an always-ready decode
    repeat (40) run_cycle(1'b0, 100, 100, 0, 0);
    // decode mostly stalled: queue fills, then drains slowly
    repeat (30) run_cycle(1'b0, 0, 100, 0, 0);
    repeat (30) run_cycle(1'b0, 20, 100, 0, 1);
    // grant gaps, variable latency, occasional redirects
    repeat (300) run_cycle(1'b0, 60, 60, 10, 2);
    // reset mid-operation with a read possibly still outstanding
    for (int r = 0; r < 6; r++) begin
      repeat (20) run_cycle(1'b0, 70, 80, 5, 3);
      run_cycle(1'b1, 50, 50, 0, 3);
    end
    // redirect-heavy traffic
    repeat (400) run_cycle(1'b0, $urandom_range(30, 100), 75, 25, 3);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
